// File: rtl/option_loader_if.sv
// Bus bundle for option_loader: parser word input, board control,
// BRAM write port and status/count outputs.
// master = the side that produces parser words and consumes status,
// slave  = the option_loader itself.
interface option_loader_if #(
  parameter int ADDR_W = 11
) ();

  // Parser side
  logic [15:0]       line_in;
  logic              write_ready;
  logic              board_done;
  logic [3:0]        n;
  logic [3:0]        m;

  // BRAM write port
  logic              bram_ready;
  logic              bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [15:0]       bram_din;

  // Per-line option counts
  logic [4:0]        count_idx;
  logic [6:0]        count_out;

  // Status
  logic [ADDR_W:0]   words_stored;
  logic              load_done;
  logic              overflow;
  logic              bad_index;

  modport master (
    output line_in, write_ready, board_done, n, m, bram_ready, count_idx,
    input  bram_we, bram_addr, bram_din, count_out,
           words_stored, load_done, overflow, bad_index
  );

  modport slave (
    input  line_in, write_ready, board_done, n, m, bram_ready, count_idx,
    output bram_we, bram_addr, bram_din, count_out,
           words_stored, load_done, overflow, bad_index
  );

endinterface

// File: rtl/option_loader.sv
// option_loader: buffers parser words in a small FIFO and streams them into
// a BRAM, one 16-bit word per write, discarding words whose line index is
// out of range for the current n x m board.
//
// Optional feature macro: LOADER_COUNT_EN
//   defined   -> a 7-bit saturating counter per line index tracks how many
//                words were written for that line; count_out reads it.
//   undefined -> no counters, count_out is tied to 0.
module option_loader #(
  parameter int ADDR_W     = 11,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_LINES  = 22
) (
  input logic            clk,
  input logic            rst,
  option_loader_if.slave bus
);

  localparam int          PTR_W        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [31:0] LP_MAX_LINES = 32'(MAX_LINES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_t            r_state;

  logic [15:0]       r_fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]    r_rd_ptr;
  logic [PTR_W:0]    r_wr_ptr;

  logic [ADDR_W-1:0] r_wptr;
  logic [ADDR_W:0]   r_words;

  logic              r_bram_we;
  logic [ADDR_W-1:0] r_bram_addr;
  logic [15:0]       r_bram_din;
  logic              r_overflow;
  logic              r_bad_index;

  // ---------------------------------------------------------------------
  // Combinational control
  // ---------------------------------------------------------------------
  logic              w_empty;
  logic              w_full;
  logic [15:0]       w_head;
  logic [4:0]        w_head_idx;
  logic [4:0]        w_line_lim;
  logic              w_idx_ok;
  logic              w_pop;
  logic              w_write;
  logic              w_push;
  logic              w_push_reject;
  logic              w_wptr_max;
  logic [6:0]        w_count_out;

  // FIFO status, head decode and the push/pop/write decisions for this cycle
  always_comb begin
    w_empty       = 1'b0;
    w_full        = 1'b0;
    w_head        = 16'd0;
    w_head_idx    = 5'd0;
    w_line_lim    = 5'd0;
    w_idx_ok      = 1'b0;
    w_pop         = 1'b0;
    w_write       = 1'b0;
    w_push        = 1'b0;
    w_push_reject = 1'b0;
    w_wptr_max    = 1'b0;

    w_empty = (r_rd_ptr == r_wr_ptr);
    w_full  = (r_rd_ptr[PTR_W] != r_wr_ptr[PTR_W]) &&
              (r_rd_ptr[PTR_W-1:0] == r_wr_ptr[PTR_W-1:0]);

    w_head     = r_fifo_mem[r_rd_ptr[PTR_W-1:0]];
    w_head_idx = w_head[15:11];
    // n and m are at most 15 each, so the sum always fits in 5 bits
    w_line_lim = {1'b0, bus.n} + {1'b0, bus.m};
    if ((w_head_idx < w_line_lim) && (32'(w_head_idx) < LP_MAX_LINES)) begin
      w_idx_ok = 1'b1;
    end else begin
      w_idx_ok = 1'b0;
    end

    // The head leaves the FIFO whenever the BRAM port is free, whether it
    // is written or discarded as a bad index.
    w_pop   = !w_empty && bus.bram_ready;
    w_write = w_pop && w_idx_ok;

    // A full FIFO still takes a word if the head leaves in the same cycle.
    if (bus.write_ready && (r_state != ST_DONE) && (!w_full || w_pop)) begin
      w_push = 1'b1;
    end else begin
      w_push = 1'b0;
    end
    w_push_reject = bus.write_ready && !w_push;

    w_wptr_max = (r_wptr == {ADDR_W{1'b1}});
  end

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  // Tracks load progress: idle, loading, draining after board_done, done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // The word is accepted first; board_done in the same cycle
          // sends the load straight to draining.
          if (bus.write_ready) begin
            if (bus.board_done) begin
              r_state <= ST_DRAIN;
            end else begin
              r_state <= ST_LOAD;
            end
          end else if (bus.board_done) begin
            // Empty board: nothing was ever buffered
            r_state <= ST_DONE;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          if (bus.board_done) begin
            r_state <= ST_DRAIN;
          end else begin
            r_state <= ST_LOAD;
          end
        end
        ST_DRAIN: begin
          // Done once nothing is buffered and nothing new is arriving
          if (w_empty && !w_push) begin
            r_state <= ST_DONE;
          end else begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DONE: begin
          r_state <= ST_DONE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Input FIFO
  // ---------------------------------------------------------------------
  // Stores accepted parser words and advances read/write pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= {(PTR_W+1){1'b0}};
      r_wr_ptr <= {(PTR_W+1){1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_mem[i] <= 16'd0;
      end
    end else begin
      if (w_push) begin
        r_fifo_mem[r_wr_ptr[PTR_W-1:0]] <= bus.line_in;
        r_wr_ptr <= r_wr_ptr + {{PTR_W{1'b0}}, 1'b1};
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + {{PTR_W{1'b0}}, 1'b1};
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
    end
  end

  // ---------------------------------------------------------------------
  // BRAM write port
  // ---------------------------------------------------------------------
  // Registers one write per valid head word; addr/din hold between writes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bram_we   <= 1'b0;
      r_bram_addr <= {ADDR_W{1'b0}};
      r_bram_din  <= 16'd0;
      r_wptr      <= {ADDR_W{1'b0}};
      r_words     <= {(ADDR_W+1){1'b0}};
    end else begin
      if (w_write) begin
        r_bram_we   <= 1'b1;
        r_bram_addr <= r_wptr;
        r_bram_din  <= w_head;
        // Natural wrap from all-ones back to address 0
        r_wptr      <= r_wptr + {{(ADDR_W-1){1'b0}}, 1'b1};
        r_words     <= r_words + {{ADDR_W{1'b0}}, 1'b1};
      end else begin
        r_bram_we   <= 1'b0;
        r_bram_addr <= r_bram_addr;
        r_bram_din  <= r_bram_din;
        r_wptr      <= r_wptr;
        r_words     <= r_words;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Sticky error flags
  // ---------------------------------------------------------------------
  // overflow: dropped word or BRAM address wrap; bad_index: discarded word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_bad_index <= 1'b0;
    end else begin
      if (w_push_reject || (w_write && w_wptr_max)) begin
        r_overflow <= 1'b1;
      end else begin
        r_overflow <= r_overflow;
      end
      if (w_pop && !w_idx_ok) begin
        r_bad_index <= 1'b1;
      end else begin
        r_bad_index <= r_bad_index;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Per-line option counters
  // ---------------------------------------------------------------------
`ifdef LOADER_COUNT_EN
  logic [6:0] r_count [MAX_LINES];

  // Counts written words per line index, saturating at 127
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_LINES; i++) begin
        r_count[i] <= 7'd0;
      end
    end else begin
      // w_write implies the index is below MAX_LINES
      if (w_write && (r_count[w_head_idx] != 7'h7F)) begin
        r_count[w_head_idx] <= r_count[w_head_idx] + 7'd1;
      end else begin
        r_count[w_head_idx] <= r_count[w_head_idx];
      end
    end
  end

  // Read port for the selected line; out-of-table indices read as 0
  always_comb begin
    w_count_out = 7'd0;
    if (32'(bus.count_idx) < LP_MAX_LINES) begin
      w_count_out = r_count[bus.count_idx];
    end else begin
      w_count_out = 7'd0;
    end
  end
`else
  logic w_unused_count_idx;

  // No counters in this build: the read port is constant zero
  always_comb begin
    w_count_out        = 7'd0;
    w_unused_count_idx = ^bus.count_idx;
  end
`endif

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign bus.bram_we      = r_bram_we;
  assign bus.bram_addr    = r_bram_addr;
  assign bus.bram_din     = r_bram_din;
  assign bus.words_stored = r_words;
  assign bus.overflow     = r_overflow;
  assign bus.bad_index    = r_bad_index;
  assign bus.count_out    = w_count_out;
  assign bus.load_done    = (r_state == ST_DONE);

endmodule

// File: tb/tb_option_loader.sv
// Testbench for option_loader: directed parser traffic, a queue-based
// reference of the loader rules checked every cycle, and hand-computed
// expectations for the key scenarios.
module tb_option_loader;

  localparam int ADDR_W     = 11;
  localparam int FIFO_DEPTH = 4;
  localparam int MAX_LINES  = 22;

  logic clk = 1'b0;
  logic rst = 1'b1;

  option_loader_if #(.ADDR_W(ADDR_W)) bus ();

  option_loader #(
    .ADDR_W    (ADDR_W),
    .FIFO_DEPTH(FIFO_DEPTH),
    .MAX_LINES (MAX_LINES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference state
  logic [15:0] mq[$];
  int          m_wp, m_words, m_addr, m_din;
  bit          m_we, m_ovf, m_bad, m_done, m_started, m_board;
  int          m_cnt [MAX_LINES];

  // Inputs as seen at the last rising edge
  logic        s_wr, s_bd, s_rdy, s_rst;
  logic [15:0] s_line;
  logic [3:0]  s_n, s_m;

  always @(posedge clk) begin
    s_wr   <= bus.write_ready;
    s_bd   <= bus.board_done;
    s_rdy  <= bus.bram_ready;
    s_rst  <= rst;
    s_line <= bus.line_in;
    s_n    <= bus.n;
    s_m    <= bus.m;
  end

  task automatic model_step();
    int sz;
    bit pop, push;
    logic [15:0] w;
    int idx;
    if (rst || s_rst) begin
      mq.delete();
      m_wp = 0; m_words = 0; m_addr = 0; m_din = 0;
      m_we = 0; m_ovf = 0; m_bad = 0; m_done = 0; m_started = 0; m_board = 0;
      for (int i = 0; i < MAX_LINES; i++) m_cnt[i] = 0;
      return;
    end
    sz   = mq.size();
    pop  = (sz > 0) && s_rdy;
    push = 0;
    if (s_wr) begin
      if (m_done) m_ovf = 1;
      else if (sz < FIFO_DEPTH || pop) push = 1;
      else m_ovf = 1;
    end
    if (!m_done) begin
      if (!m_started) begin
        if (s_wr) begin
          m_started = 1;
          if (s_bd) m_board = 1;
        end else if (s_bd) begin
          m_done = 1;
        end
      end else if (m_board) begin
        if (sz == 0 && !push) m_done = 1;
      end else if (s_bd) begin
        m_board = 1;
      end
    end
    m_we = 0;
    if (pop) begin
      w   = mq.pop_front();
      idx = int'(w[15:11]);
      if (idx < int'(s_n) + int'(s_m) && idx < MAX_LINES) begin
        m_we   = 1;
        m_addr = m_wp;
        m_din  = int'(w);
        if (m_wp == (1 << ADDR_W) - 1) begin
          m_ovf = 1;
          m_wp  = 0;
        end else begin
          m_wp++;
        end
        m_words++;
        if (m_cnt[idx] < 127) m_cnt[idx]++;
      end else begin
        m_bad = 1;
      end
    end
    if (push) mq.push_back(s_line);
  endtask

  function automatic int exp_count(input logic [4:0] ci);
`ifdef LOADER_COUNT_EN
    if (int'(ci) < MAX_LINES) return m_cnt[ci];
    return 0;
`else
    return 0;
`endif
  endfunction

  // Observed write log
  int log_addr[$];
  int log_din[$];
  int cyc_no      = 0;
  int last_we_cyc = -1;
  int done_cyc    = -1;

  always @(negedge clk) begin
    cyc_no++;
    model_step();
    if (bus.bram_we === 1'b1) begin
      log_addr.push_back(int'(bus.bram_addr));
      log_din.push_back(int'(bus.bram_din));
      last_we_cyc = cyc_no;
    end
    if (bus.load_done === 1'b1 && done_cyc < 0) done_cyc = cyc_no;
    chk("bram_we",      32'(bus.bram_we),      32'(m_we));
    chk("bram_addr",    32'(bus.bram_addr),    32'(m_addr));
    chk("bram_din",     32'(bus.bram_din),     32'(m_din));
    chk("words_stored", 32'(bus.words_stored), 32'(m_words));
    chk("overflow",     32'(bus.overflow),     32'(m_ovf));
    chk("bad_index",    32'(bus.bad_index),    32'(m_bad));
    chk("load_done",    32'(bus.load_done),    32'(m_done));
    chk("count_out",    32'(bus.count_out),    32'(exp_count(bus.count_idx)));
  end

  // All stimulus tasks start and end 1 time unit after a rising edge
  task automatic drive(input logic wr, input logic [15:0] w, input logic bd);
    bus.write_ready = wr;
    bus.line_in     = w;
    bus.board_done  = bd;
    @(posedge clk); #1;
    bus.write_ready = 1'b0;
    bus.board_done  = 1'b0;
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_din.delete();
    last_we_cyc = -1;
    done_cyc    = -1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.write_ready = 1'b0;
    bus.board_done  = 1'b0;
    #2;
    clear_log();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && bus.load_done !== 1'b1; i++) idle(1);
  endtask

  initial begin
    #1000000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    bus.line_in     = 16'h0000;
    bus.write_ready = 1'b0;
    bus.board_done  = 1'b0;
    bus.n           = 4'd4;
    bus.m           = 4'd4;
    bus.bram_ready  = 1'b1;
    bus.count_idx   = 5'd1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("rst_we",    32'(bus.bram_we),      32'd0);
    chk("rst_words", 32'(bus.words_stored), 32'd0);
    chk("rst_done",  32'(bus.load_done),    32'd0);
    chk("rst_ovf",   32'(bus.overflow),     32'd0);

    // Three words, board_done with the last one
    drive(1'b1, 16'h0001, 1'b0);
    drive(1'b1, 16'h0803, 1'b0);
    drive(1'b1, 16'h1002, 1'b1);
    wait_done(20);
    idle(1);
    chk("t1_nwrites", 32'(log_addr.size()), 32'd3);
    if (log_addr.size() == 3) begin
      chk("t1_addr0", 32'(log_addr[0]), 32'd0);
      chk("t1_din0",  32'(log_din[0]),  32'h0001);
      chk("t1_addr1", 32'(log_addr[1]), 32'd1);
      chk("t1_din1",  32'(log_din[1]),  32'h0803);
      chk("t1_addr2", 32'(log_addr[2]), 32'd2);
      chk("t1_din2",  32'(log_din[2]),  32'h1002);
    end
    chk("t1_words", 32'(bus.words_stored), 32'd3);
`ifdef LOADER_COUNT_EN
    chk("t1_count1", 32'(bus.count_out), 32'd1);
`else
    chk("t1_count1", 32'(bus.count_out), 32'd0);
`endif
    chk("t1_done",     32'(bus.load_done),                  32'd1);
    chk("t1_done_lag", 32'(done_cyc - last_we_cyc),        32'd1);

    // Five words into a stalled 4-entry FIFO
    do_reset();
    bus.bram_ready = 1'b0;
    for (int i = 0; i < 5; i++) drive(1'b1, 16'(i), 1'b0);
    chk("t2_ovf",     32'(bus.overflow),        32'd1);
    chk("t2_nowrite", 32'(log_addr.size()),     32'd0);
    bus.bram_ready = 1'b1;
    idle(8);
    chk("t2_nwrites", 32'(log_addr.size()),     32'd4);
    if (log_din.size() == 4) chk("t2_last_din", 32'(log_din[3]), 32'h0003);

    // Out-of-range index on a 4x4 board
    do_reset();
    drive(1'b1, 16'h4000, 1'b0);
    idle(4);
    chk("t3_bad",      32'(bus.bad_index),    32'd1);
    chk("t3_words",    32'(bus.words_stored), 32'd0);
    chk("t3_nowrite",  32'(log_addr.size()),  32'd0);

    // Full FIFO accepts a word when the head leaves in the same cycle
    do_reset();
    bus.bram_ready = 1'b0;
    for (int i = 0; i < 4; i++) drive(1'b1, 16'h0010 + 16'(i), 1'b0);
    bus.bram_ready = 1'b1;
    drive(1'b1, 16'h0014, 1'b0);
    idle(8);
    chk("t4_ovf",     32'(bus.overflow),       32'd0);
    chk("t4_nwrites", 32'(log_addr.size()),    32'd5);

    // Reset mid-load with two words still buffered
    do_reset();
    bus.bram_ready = 1'b0;
    drive(1'b1, 16'h0005, 1'b0);
    drive(1'b1, 16'h0006, 1'b0);
    drive(1'b1, 16'h0007, 1'b0);
    bus.bram_ready = 1'b1;
    idle(1);
    bus.bram_ready = 1'b0;
    chk("t5_pre_we",  32'(bus.bram_we),  32'd1);
    chk("t5_pre_din", 32'(bus.bram_din), 32'h0005);
    #1;
    rst = 1'b1;
    #1;
    chk("t5_we",    32'(bus.bram_we),      32'd0);
    chk("t5_addr",  32'(bus.bram_addr),    32'd0);
    chk("t5_din",   32'(bus.bram_din),     32'd0);
    chk("t5_words", 32'(bus.words_stored), 32'd0);
    chk("t5_done",  32'(bus.load_done),    32'd0);
    chk("t5_bad",   32'(bus.bad_index),    32'd0);
    clear_log();
    @(posedge clk); #1;
    rst = 1'b0;
    bus.bram_ready = 1'b1;
    idle(5);
    chk("t5_nowrite", 32'(log_addr.size()), 32'd0);

    // Empty board, then a word arriving after completion
    do_reset();
    drive(1'b0, 16'h0000, 1'b1);
    idle(1);
    chk("t6_done", 32'(bus.load_done), 32'd1);
    drive(1'b1, 16'h0001, 1'b0);
    idle(3);
    chk("t6_ovf",     32'(bus.overflow),      32'd1);
    chk("t6_nowrite", 32'(log_addr.size()),   32'd0);

    // BRAM address wrap after 2^ADDR_W writes
    do_reset();
    bus.count_idx = 5'd0;
    for (int i = 0; i < 2049; i++) drive(1'b1, 16'h0000, 1'b0);
    idle(3);
    chk("t7_nwrites", 32'(log_addr.size()),    32'd2049);
    if (log_addr.size() == 2049) begin
      chk("t7_addr_top",  32'(log_addr[2047]), 32'd2047);
      chk("t7_addr_wrap", 32'(log_addr[2048]), 32'd0);
    end
    chk("t7_ovf",   32'(bus.overflow),     32'd1);
    chk("t7_words", 32'(bus.words_stored), 32'd2049);
`ifdef LOADER_COUNT_EN
    chk("t7_count_sat", 32'(bus.count_out), 32'd127);
`else
    chk("t7_count_sat", 32'(bus.count_out), 32'd0);
`endif
    bus.count_idx = 5'd25;
    idle(1);
    chk("t7_count_oob", 32'(bus.count_out), 32'd0);

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/option_loader.md
OPTION_LOADER -- requirements
Module: option_loader

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 11, giving the BRAM address width.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, giving the input FIFO entries (power of two, >=2).
REQ-003 The block SHALL have parameter MAX_LINES, default 22, giving the line-index table size.
REQ-004 The block SHALL have ports clk (input, 1, system clock) and rst (input, 1, asynchronous active-high reset); one clock; reset is asynchronous and active-high.
REQ-005 The block SHALL have ports line_in (input, 16, parser word: [15:11] line index, [10:0] option bits) and write_ready (input, 1, line_in valid this cycle).
REQ-006 The block SHALL have ports board_done (input, 1, parser finished pulse), n (input, 4, rows) and m (input, 4, columns).
REQ-007 The block SHALL have ports bram_ready (input, 1, BRAM port free) and bram_we (output, 1, write strobe).
REQ-008 The block SHALL have ports bram_addr (output, ADDR_W, write address) and bram_din (output, 16, write data).
REQ-009 The block SHALL have ports count_idx (input, 5, line select) and count_out (output, 7, options stored for count_idx).
REQ-010 The block SHALL have ports words_stored (output, ADDR_W+1), load_done (output, 1), overflow (output, 1, sticky) and bad_index (output, 1, sticky).

Function
REQ-011 The block SHALL use FSM states IDLE, LOAD, DRAIN, DONE; IDLE->LOAD on first accepted write_ready; LOAD->DRAIN on board_done; DRAIN->DONE when FIFO empty and no write in flight; DONE held until rst.
REQ-012 The block SHALL, in IDLE, treat board_done with an empty FIFO as IDLE->DONE directly (empty board).
REQ-013 The block SHALL push line_in into the FIFO on write_ready in IDLE, LOAD or DRAIN; in DONE, words are ignored and overflow set.
REQ-014 The block SHALL accept a push when the FIFO is full only if a pop occurs the same cycle; otherwise the word is dropped and overflow set.
REQ-015 The block SHALL pop the FIFO head when the FIFO is non-empty and bram_ready=1, registering bram_we=1, bram_addr=write pointer, bram_din=word on the next clock edge (push-to-write latency 1 cycle minimum).
REQ-016 The block SHALL hold bram_we=1 for exactly one cycle per word, with addr/din stable while bram_we=1.
REQ-017 The block SHALL increment the write pointer and words_stored after each write; at pointer 2^ADDR_W-1 the next write wraps to 0 and sets overflow.
REQ-018 The block SHALL discard (pop without writing) any head word whose index >= n+m or >= MAX_LINES, setting bad_index.
REQ-019 The block SHALL treat board_done coincident with write_ready as accepting the word first, then entering DRAIN.
REQ-020 The block SHALL assert load_done combinationally equal to (state==DONE).

Reset
REQ-021 The block SHALL, on rst, asynchronously clear FSM to IDLE, FIFO pointers, write pointer, words_stored, all counts, bram_we, bram_addr, bram_din, overflow, bad_index and load_done to 0.
REQ-022 The block SHALL abandon any partial load on rst mid-operation with no further bram_we until new words arrive.

Configuration
REQ-023 The block SHALL, with LOADER_COUNT_EN defined, keep a 7-bit saturating (at 127) counter per line index, incremented on each written word, and drive count_out = counter[count_idx] combinationally (0 for count_idx >= MAX_LINES).
REQ-024 The block SHALL, without LOADER_COUNT_EN, omit the counters and tie count_out to 0.

Verification
REQ-025 Bench SHALL check: n=m=4, words 0x0001,0x0803,0x1002 with bram_ready=1 -> writes at addr 0,1,2 with those data, words_stored=3, count_out(idx1)=1.
REQ-026 Bench SHALL check: bram_ready=0, five write_ready pulses (FIFO_DEPTH=4) -> fifth dropped, overflow=1, then bram_ready=1 writes exactly 4 words.
REQ-027 Bench SHALL check: n=m=4, word 0x4000 (index 8) -> no bram_we, bad_index=1, words_stored unchanged.
REQ-028 Bench SHALL check: board_done same cycle as last write_ready -> last word written, then load_done=1 one cycle after FIFO empties.
REQ-029 Bench SHALL check: rst asserted mid-load with FIFO holding 2 words -> bram_we=0, all outputs 0, state IDLE immediately.
REQ-030 Bench SHALL check: LOADER_COUNT_EN undefined, any traffic -> count_out=0 throughout.
